// File: rtl/fetch_ctrl.sv
// Fetch front end: drives the instruction-memory PC and pairs each returned
// instruction with its PC for decode, with stall hold buffer and branch squash.
module fetch_ctrl #(
  parameter int unsigned WORD      = 32,
  parameter int unsigned INSTR_LEN = 32,
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter int unsigned PC_INC    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [WORD-1:0]      branch_target,
  input  logic [INSTR_LEN-1:0] instruction,
  output logic [WORD-1:0]      pc,
  output logic [WORD-1:0]      dec_pc,
  output logic [INSTR_LEN-1:0] dec_instr,
  output logic                 dec_valid
);

  logic [WORD-1:0]      r_pc;
  logic [WORD-1:0]      r_f_pc;
  logic                 r_f_valid;
  logic [INSTR_LEN-1:0] r_hold_instr;
  logic                 r_hold_valid;
  logic [WORD-1:0]      w_pc_next;

  assign w_pc_next = r_pc + WORD'(PC_INC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_f_pc       <= '0;
      r_f_valid    <= 1'b0;
      r_hold_instr <= '0;
      r_hold_valid <= 1'b0;
    end else if (branch_taken) begin
      // Redirect wins over stall; whatever is in flight is squashed.
      r_pc         <= branch_target;
      r_f_valid    <= 1'b0;
      r_hold_valid <= 1'b0;
    end else if (stall) begin
      // pc runs one ahead of f_pc, so the bus drifts after this edge: keep imem[f_pc].
      if (r_f_valid && !r_hold_valid) begin
        r_hold_instr <= instruction;
        r_hold_valid <= 1'b1;
      end
    end else begin
      r_f_pc       <= r_pc;
      r_f_valid    <= 1'b1;
      r_pc         <= w_pc_next;
      r_hold_valid <= 1'b0;
    end
  end

  assign pc        = r_pc;
  assign dec_pc    = r_f_pc;
  assign dec_valid = r_f_valid;

  always_comb begin
    dec_instr = '0;
    if (r_hold_valid)   dec_instr = r_hold_instr;
    else if (r_f_valid) dec_instr = instruction;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: slot-level reference model, directed scenarios with
// literal expectations, then randomized stall/branch/reset traffic.
module tb_fetch_ctrl;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [W-1:0]  branch_target = '0;
  logic [W-1:0]  instruction = '0;
  logic [W-1:0]  pc, dec_pc, dec_instr;
  logic          dec_valid;

  int total = 0;
  int bad   = 0;

  fetch_ctrl #(.WORD(W), .INSTR_LEN(W), .RESET_PC('0), .PC_INC(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .instruction(instruction),
    .pc(pc), .dec_pc(dec_pc), .dec_instr(dec_instr), .dec_valid(dec_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] imem(input logic [W-1:0] a);
    return a + 32'd100;
  endfunction

  // Synchronous memory: bus shows imem[pc sampled at previous edge].
  always @(posedge clk) instruction <= imem(pc);

  // Reference model: the decode slot as a whole, plus the fetch address.
  logic [W-1:0] m_pc = '0;
  logic [W-1:0] m_spc = '0;
  logic [W-1:0] m_sinstr = '0;
  logic         m_sv = 1'b0;

  task automatic model_reset();
    m_pc = '0; m_spc = '0; m_sinstr = '0; m_sv = 1'b0;
  endtask

  task automatic model_step();
    if (rst) model_reset();
    else if (branch_taken) begin
      m_pc = branch_target;
      m_sv = 1'b0;
    end else if (!stall) begin
      m_spc    = m_pc;
      m_sinstr = imem(m_pc);
      m_sv     = 1'b1;
      m_pc     = m_pc + 32'd4;
    end
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("pc", pc, m_pc);
    chk("dec_valid", {31'd0, dec_valid}, {31'd0, m_sv});
    chk("dec_pc", dec_pc, m_spc);
    chk("dec_instr", dec_instr, m_sv ? m_sinstr : '0);
  endtask

  // One clock: apply inputs, step model at the edge, compare at the falling edge.
  task automatic cyc(input logic s, input logic b, input logic [W-1:0] t);
    stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'd0, dec_valid}, 32'h0);
    chk("rst_instr", dec_instr, 32'h0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    cyc(0, 0, 0);
    rst = 1'b0;

    cyc(0, 0, 0);
    chk("first_pc", dec_pc, 32'h0);
    chk("first_instr", dec_instr, 32'd100);
    chk("first_valid", {31'd0, dec_valid}, 32'h1);
    cyc(0, 0, 0);
    chk("seq_4", dec_pc, 32'h4);
    cyc(0, 0, 0);
    chk("seq_8", dec_pc, 32'h8);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0);
      chk("stall_pc8", dec_pc, 32'h8);
      chk("stall_instr", dec_instr, 32'd108);
      chk("stall_fetch", pc, 32'd12);
    end
    cyc(0, 0, 0);
    chk("rel_12", dec_pc, 32'd12);
    chk("rel_12_instr", dec_instr, 32'd112);
    cyc(0, 0, 0);
    chk("rel_16", dec_pc, 32'd16);

    cyc(0, 1, 32'h40);
    chk("br_bubble", {31'd0, dec_valid}, 32'h0);
    cyc(0, 0, 0);
    chk("br_pc", dec_pc, 32'h40);
    chk("br_instr", dec_instr, 32'h40 + 32'd100);
    chk("br_fetch", pc, 32'h44);

    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 32'h80);
    chk("brst_bubble", {31'd0, dec_valid}, 32'h0);
    cyc(0, 0, 0);
    chk("brst_pc", dec_pc, 32'h80);
    chk("brst_instr", dec_instr, 32'h80 + 32'd100);

    cyc(0, 1, 32'hC0);
    cyc(1, 0, 0);
    chk("bub_stall_v", {31'd0, dec_valid}, 32'h0);
    cyc(1, 0, 0);
    chk("bub_stall_i", dec_instr, 32'h0);
    cyc(0, 0, 0);
    chk("bub_rel_pc", dec_pc, 32'hC0);
    chk("bub_rel_instr", dec_instr, 32'hC0 + 32'd100);

    cyc(0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0);
    chk("wrap_fetch", pc, 32'h0);

    cyc(1, 0, 0);
    cyc(1, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", {31'd0, dec_valid}, 32'h0);
    chk("arst_instr", dec_instr, 32'h0);
    chk("arst_dec_pc", dec_pc, 32'h0);
    cyc(1, 0, 0);
    rst = 1'b0;
    cyc(0, 0, 0);
    chk("restart_pc", dec_pc, 32'h0);
    chk("restart_instr", dec_instr, 32'd100);

    for (int i = 0; i < 3000; i++) begin
      logic s, b;
      logic [W-1:0] t;
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 10);
      t = ($urandom_range(0, 3) == 0) ? $urandom : {20'd0, $urandom_range(0, 4095) & 12'hFFC};
      rst = ($urandom_range(0, 199) == 0);
      cyc(s, b, t);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
